// File: rtl/catcore_memoria_pkg.sv
// Shared definitions for the CatCORE data-memory load/store initiator:
// FSM state encoding and the default memory geometry.
package catcore_memoria_pkg;

   localparam int LARGURA_DADOS_PADRAO    = 32;
   localparam int LARGURA_ENDERECO_PADRAO = 32;
   localparam int PROFUNDIDADE_PADRAO     = 50;

   typedef enum logic [2:0] {
      OCIOSO     = 3'd0,
      ESCREVE    = 3'd1,
      LE_PULSO   = 3'd2,
      LE_CAPTURA = 3'd3,
      RESPONDE   = 3'd4
   } estado_t;

endpackage

// File: rtl/controlador_memoria_dados.sv
// Load/store initiator for the CatCORE data memory. Accepts one request at a
// time, sequences the memory write enable / read strobe (clockAuto) and returns
// a single-cycle response pulse.
// Optional bounds check: define CATCORE_LSU_LIMITE_EN to reject addresses
// >= PROFUNDIDADE with resp_erro instead of touching the memory.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// OCIOSO     | idle, req_pronto high, waiting for a request
// ESCREVE    | write enable high for one cycle, memory writes on closing edge
// LE_PULSO   | read strobe high for one cycle
// LE_CAPTURA | strobe low, mem_saida registered into resp_dado at closing edge
// RESPONDE   | resp_valido pulse, back to OCIOSO
module controlador_memoria_dados
   import catcore_memoria_pkg::*;
#(
   parameter int LARGURA_DADOS    = LARGURA_DADOS_PADRAO,
   parameter int LARGURA_ENDERECO = LARGURA_ENDERECO_PADRAO,
   parameter int PROFUNDIDADE     = PROFUNDIDADE_PADRAO
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        req_valido,
   output logic                        req_pronto,
   input  logic                        req_escrita,
   input  logic [LARGURA_ENDERECO-1:0] req_endereco,
   input  logic [LARGURA_DADOS-1:0]    req_dado,
   output logic                        resp_valido,
   output logic [LARGURA_DADOS-1:0]    resp_dado,
   output logic                        resp_erro,
   output logic [LARGURA_ENDERECO-1:0] mem_endereco,
   output logic [LARGURA_DADOS-1:0]    mem_dado,
   output logic                        mem_controle_escrita,
   output logic                        mem_pulso_leitura,
   input  logic [LARGURA_DADOS-1:0]    mem_saida
);

   estado_t                     estado_q;
   logic                        req_pronto_q;
   logic                        resp_valido_q;
   logic                        resp_erro_q;
   logic [LARGURA_DADOS-1:0]    resp_dado_q;
   logic [LARGURA_ENDERECO-1:0] mem_endereco_q;
   logic [LARGURA_DADOS-1:0]    mem_dado_q;
   logic                        mem_escrita_q;
   logic                        mem_leitura_q;
   logic                        fora_faixa_d;
   logic                        aceita_d;

`ifdef CATCORE_LSU_LIMITE_EN
   // Unsigned full-width compare against the implemented memory depth.
   assign fora_faixa_d = (req_endereco >= LARGURA_ENDERECO'(PROFUNDIDADE));
`else
   // No bounds check: every address is forwarded, resp_erro stays 0.
   assign fora_faixa_d = 1'b0;
`endif

   // req_pronto_q is only high while idle, so it qualifies the handshake.
   assign aceita_d = req_pronto_q && req_valido;

   // Request/response sequencer; every output is a register of this block.
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q       <= OCIOSO;
         req_pronto_q   <= 1'b0;
         resp_valido_q  <= 1'b0;
         resp_erro_q    <= 1'b0;
         resp_dado_q    <= '0;
         mem_endereco_q <= '0;
         mem_dado_q     <= '0;
         mem_escrita_q  <= 1'b0;
         mem_leitura_q  <= 1'b0;
      end else begin
         mem_escrita_q <= 1'b0;
         mem_leitura_q <= 1'b0;
         resp_valido_q <= 1'b0;
         case (estado_q)
            OCIOSO: begin
               req_pronto_q <= 1'b1;
               if (aceita_d) begin
                  req_pronto_q   <= 1'b0;
                  mem_endereco_q <= req_endereco;
                  mem_dado_q     <= req_dado;
                  if (fora_faixa_d) begin
                     // Out-of-range: skip the memory, answer next cycle.
                     estado_q      <= RESPONDE;
                     resp_valido_q <= 1'b1;
                     resp_erro_q   <= 1'b1;
                     resp_dado_q   <= '0;
                  end else if (req_escrita) begin
                     estado_q      <= ESCREVE;
                     mem_escrita_q <= 1'b1;
                  end else begin
                     estado_q      <= LE_PULSO;
                     mem_leitura_q <= 1'b1;
                  end
               end
            end
            ESCREVE: begin
               estado_q      <= RESPONDE;
               resp_valido_q <= 1'b1;
               resp_erro_q   <= 1'b0;
               resp_dado_q   <= '0;
            end
            LE_PULSO: begin
               estado_q <= LE_CAPTURA;
            end
            LE_CAPTURA: begin
               estado_q      <= RESPONDE;
               resp_valido_q <= 1'b1;
               resp_erro_q   <= 1'b0;
               resp_dado_q   <= mem_saida;
            end
            RESPONDE: begin
               estado_q     <= OCIOSO;
               resp_erro_q  <= 1'b0;
               req_pronto_q <= 1'b1;
            end
            default: begin
               estado_q     <= OCIOSO;
               req_pronto_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_pronto           = req_pronto_q;
   assign resp_valido          = resp_valido_q;
   assign resp_erro            = resp_erro_q;
   assign resp_dado            = resp_dado_q;
   assign mem_endereco         = mem_endereco_q;
   assign mem_dado             = mem_dado_q;
   assign mem_controle_escrita = mem_escrita_q;
   assign mem_pulso_leitura    = mem_leitura_q;

endmodule

// File: tb/tb_controlador_memoria_dados.sv
// Bench for controlador_memoria_dados: behavioural data memory, scoreboard of
// expected responses, a vector table plus hand-written corner sequences.
module tb_controlador_memoria_dados;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valido = 1'b0;
   logic        req_pronto;
   logic        req_escrita = 1'b0;
   logic [31:0] req_endereco = '0;
   logic [31:0] req_dado = '0;
   logic        resp_valido;
   logic [31:0] resp_dado;
   logic        resp_erro;
   logic [31:0] mem_endereco;
   logic [31:0] mem_dado;
   logic        mem_controle_escrita;
   logic        mem_pulso_leitura;
   logic [31:0] mem_saida = '0;

   controlador_memoria_dados dut (
      .clock                (clock),
      .reset                (reset),
      .req_valido           (req_valido),
      .req_pronto           (req_pronto),
      .req_escrita          (req_escrita),
      .req_endereco         (req_endereco),
      .req_dado             (req_dado),
      .resp_valido          (resp_valido),
      .resp_dado            (resp_dado),
      .resp_erro            (resp_erro),
      .mem_endereco         (mem_endereco),
      .mem_dado             (mem_dado),
      .mem_controle_escrita (mem_controle_escrita),
      .mem_pulso_leitura    (mem_pulso_leitura),
      .mem_saida            (mem_saida)
   );

   always #5 clock = ~clock;

   int ciclo = 0;
   always @(posedge clock) ciclo <= ciclo + 1;

   // Data memory: writes on the enable, read data updates on the strobe.
   logic [31:0] mem [64] = '{default: 32'h0};
   always @(posedge clock) begin
      if (mem_controle_escrita) mem[mem_endereco[5:0]] <= mem_dado;
      if (mem_pulso_leitura)    mem_saida <= mem[mem_endereco[5:0]];
   end

   typedef struct {
      logic [31:0] dado;
      bit          erro;
      int          due;
   } esperado_t;

   typedef struct {
      bit          escrita;
      logic [31:0] endereco;
      logic [31:0] dado;
      logic [31:0] exp_dado;
      bit          exp_erro;
      int          exp_lat;
   } vetor_t;

   esperado_t fila[$];
   esperado_t e_mon;
   int n_asserts = 0;
   int n_falhas  = 0;
   int resp_total = 0;
   int we_cnt = 0, we_ciclo = -1, rd_cnt = 0, rd_ciclo = -1;
   logic [31:0] we_end = '0, we_dado = '0, rd_end = '0;

   task automatic checa(string nome, logic [63:0] atual, logic [63:0] esperado);
      n_asserts++;
      if (atual !== esperado) begin
         n_falhas++;
         $display("FAIL %s: obtido 0x%0h, esperado 0x%0h (ciclo %0d)", nome, atual, esperado, ciclo);
      end
   endtask

   // Monitor: strobe log and scoreboard pop/compare, sampled on the falling edge.
   always @(negedge clock) begin
      if (!reset) fila.delete();
      if (mem_controle_escrita) begin
         we_cnt++; we_ciclo = ciclo; we_end = mem_endereco; we_dado = mem_dado;
      end
      if (mem_pulso_leitura) begin
         rd_cnt++; rd_ciclo = ciclo; rd_end = mem_endereco;
      end
      if (resp_valido) begin
         resp_total++;
         if (fila.size() == 0) begin
            n_asserts++; n_falhas++;
            $display("FAIL resp_inesperada: obtido resp_valido=1, esperado 0 (ciclo %0d)", ciclo);
         end else begin
            e_mon = fila.pop_front();
            checa("resp_ciclo", ciclo, e_mon.due);
            checa("resp_dado", resp_dado, e_mon.dado);
            checa("resp_erro", resp_erro, e_mon.erro);
         end
      end else if (fila.size() > 0 && ciclo > fila[0].due) begin
         n_asserts++; n_falhas++;
         $display("FAIL resp_ausente: obtido nenhuma resposta, esperado no ciclo %0d", fila[0].due);
         void'(fila.pop_front());
      end
   end

   task automatic espera_hs(output int hs);
      hs = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (req_pronto) begin
            hs = ciclo;
            break;
         end
      end
      if (hs < 0) begin
         n_asserts++; n_falhas++;
         $display("FAIL handshake_timeout: obtido req_pronto=0, esperado 1 em 20 ciclos");
      end
   endtask

   task automatic empurra(int hs, logic [31:0] d, bit er, int lat);
      esperado_t e;
      e.dado = d; e.erro = er; e.due = hs + lat;
      if (hs >= 0) fila.push_back(e);
   endtask

   task automatic envia(bit esc, logic [31:0] ende, logic [31:0] d,
                        logic [31:0] exp_d, bit exp_e, int lat, output int hs);
      @(posedge clock); #1;
      req_valido = 1'b1; req_escrita = esc; req_endereco = ende; req_dado = d;
      espera_hs(hs);
      empurra(hs, exp_d, exp_e, lat);
      @(posedge clock); #1;
      req_valido = 1'b0;
   endtask

   task automatic espera_vazio();
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (fila.size() == 0) break;
      end
      checa("fila_vazia", fila.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: obtido simulacao parada, esperado $finish");
      $fatal(1, "watchdog");
   end

   vetor_t tab[10];
   int h, h0, h1, h2, s0, w0, r0;

   initial begin
      tab[0] = '{1'b1, 32'd10, 32'h12345678, 32'h0, 1'b0, 2};
      tab[1] = '{1'b1, 32'd49, 32'hCAFEF00D, 32'h0, 1'b0, 2};
      tab[2] = '{1'b0, 32'd10, 32'h0, 32'h12345678, 1'b0, 3};
      tab[3] = '{1'b0, 32'd49, 32'h0, 32'hCAFEF00D, 1'b0, 3};
      tab[4] = '{1'b1, 32'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 2};
      tab[5] = '{1'b0, 32'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 3};
`ifdef CATCORE_LSU_LIMITE_EN
      tab[6] = '{1'b1, 32'd50, 32'h5A5A5A5A, 32'h0, 1'b1, 1};
      tab[7] = '{1'b0, 32'd50, 32'h0, 32'h0, 1'b1, 1};
      tab[8] = '{1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1};
`else
      tab[6] = '{1'b1, 32'd50, 32'h5A5A5A5A, 32'h0, 1'b0, 2};
      tab[7] = '{1'b0, 32'd50, 32'h0, 32'h5A5A5A5A, 1'b0, 3};
      tab[8] = '{1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 3};
`endif
      tab[9] = '{1'b0, 32'd10, 32'h0, 32'h12345678, 1'b0, 3};

      // Reset held for three edges: every output low.
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checa("reset_saidas", {req_pronto, resp_valido, resp_erro, mem_controle_escrita,
                                mem_pulso_leitura, |mem_endereco, |mem_dado, |resp_dado}, 0);
      end
      reset = 1'b1;
      @(negedge clock);
      checa("pronto_apos_reset", req_pronto, 1);

      // Store addr 5: write enable only in cycle 1, response in cycle 2.
      w0 = we_cnt; r0 = rd_cnt;
      envia(1'b1, 32'd5, 32'hDEADBEEF, 32'h0, 1'b0, 2, h);
      espera_vazio();
      checa("store_we_pulsos", we_cnt - w0, 1);
      checa("store_we_ciclo", we_ciclo, h + 1);
      checa("store_we_end", we_end, 5);
      checa("store_we_dado", we_dado, 32'hDEADBEEF);
      checa("store_sem_leitura", rd_cnt - r0, 0);

      // Load addr 5: read strobe only in cycle 1, data in cycle 3.
      w0 = we_cnt; r0 = rd_cnt;
      envia(1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 3, h);
      espera_vazio();
      checa("load_rd_pulsos", rd_cnt - r0, 1);
      checa("load_rd_ciclo", rd_ciclo, h + 1);
      checa("load_rd_end", rd_end, 5);
      checa("load_sem_escrita", we_cnt - w0, 0);
      repeat (2) @(negedge clock);
      checa("resp_dado_mantido", resp_dado, 32'hDEADBEEF);
      checa("mem_endereco_mantido", mem_endereco, 5);

      // req_valido held high across load, store, load.
      @(posedge clock); #1;
      req_valido = 1'b1; req_escrita = 1'b0; req_endereco = 32'd5; req_dado = '0;
      espera_hs(h0);
      empurra(h0, 32'hDEADBEEF, 1'b0, 3);
      @(posedge clock); #1;
      req_escrita = 1'b1; req_endereco = 32'd7; req_dado = 32'h0BADCAFE;
      espera_hs(h1);
      empurra(h1, 32'h0, 1'b0, 2);
      @(posedge clock); #1;
      req_escrita = 1'b0; req_endereco = 32'd7; req_dado = '0;
      espera_hs(h2);
      empurra(h2, 32'h0BADCAFE, 1'b0, 3);
      @(posedge clock); #1;
      req_valido = 1'b0;
      espera_vazio();
      checa("b2b_hs_store", h1 - h0, 4);
      checa("b2b_hs_load", h2 - h0, 7);

      // Vector table, including the depth boundary.
      for (int i = 0; i < 10; i++) begin
         s0 = we_cnt + rd_cnt;
         envia(tab[i].escrita, tab[i].endereco, tab[i].dado,
               tab[i].exp_dado, tab[i].exp_erro, tab[i].exp_lat, h);
         espera_vazio();
         checa("tab_estrobos", (we_cnt + rd_cnt) - s0, tab[i].exp_erro ? 0 : 1);
      end

      // Reset during LE_CAPTURA: the load is abandoned.
      envia(1'b0, 32'd49, 32'h0, 32'hCAFEF00D, 1'b0, 3, h);
      @(posedge clock); #1;
      reset = 1'b0;
      r0 = resp_total;
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      checa("pronto_em_reset", req_pronto, 0);
      @(negedge clock);
      checa("pronto_pos_reset", req_pronto, 1);
      repeat (3) @(negedge clock);
      checa("sem_resp_abandonada", resp_total - r0, 0);
      envia(1'b0, 32'd10, 32'h0, 32'h12345678, 1'b0, 3, h);
      espera_vazio();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_falhas);
      $finish;
   end

endmodule

// File: doc/controlador_memoria_dados.md
# controlador_memoria_dados

Load/store initiator that drives the CatCORE data memory on behalf of the processor datapath.
- Accepts one load or store request at a time through a valid/ready handshake.
- Sequences the memory's write-enable and its separate read strobe (the memory's `clockAuto` input).
- Returns load data or store completion as a single-cycle response pulse.
- Sits between the execute/control FSM and the data memory.

## Interface
Parameters:
- LARGURA_DADOS, 32, data word width
- LARGURA_ENDERECO, 32, word-address width
- PROFUNDIDADE, 50, number of words implemented in data memory

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low
- req_valido  input  1  request present
- req_pronto  output  1  block can accept a request
- req_escrita  input  1  1 = store, 0 = load
- req_endereco  input  LARGURA_ENDERECO  word address
- req_dado  input  LARGURA_DADOS  store data
- resp_valido  output  1  one-cycle completion pulse
- resp_dado  output  LARGURA_DADOS  load data (0 for stores/errors)
- resp_erro  output  1  out-of-range access (only with bounds check)
- mem_endereco  output  LARGURA_ENDERECO  to memory address
- mem_dado  output  LARGURA_DADOS  to memory write data
- mem_controle_escrita  output  1  to memory write enable
- mem_pulso_leitura  output  1  to memory `clockAuto` read strobe
- mem_saida  input  LARGURA_DADOS  from memory read data

## Operation
States: OCIOSO, ESCREVE, LE_PULSO, LE_CAPTURA, RESPONDE.
- **OCIOSO**
  - req_pronto=1.
  - On req_valido&&req_pronto, latch the request and register mem_endereco/mem_dado.
  - Next state: ESCREVE for a store, LE_PULSO for a load.
- **ESCREVE**
  - mem_controle_escrita=1 for exactly this cycle; the memory writes on the closing edge.
  - Next state: RESPONDE.
- **LE_PULSO**
  - mem_pulso_leitura=1 for exactly this cycle.
  - Next state: LE_CAPTURA.
- **LE_CAPTURA**
  - Strobe low; mem_saida is registered into resp_dado on the closing edge.
  - Next state: RESPONDE.
- **RESPONDE**
  - resp_valido=1 for one cycle; no response backpressure.
  - Next state: OCIOSO.
- req_pronto=0 in every state except OCIOSO; requests offered while busy are not consumed.
- mem_endereco holds its last value between requests. It is stable from ESCREVE/LE_PULSO through the end of RESPONDE.
- All mem_* and resp_* outputs are registered.
- Address compare is unsigned and full width.

## Timing
- Reset (reset==0 at an edge):
  - State goes to OCIOSO.
  - All outputs go to 0, including req_pronto while reset is held.
  - req_pronto goes to 1 on the first cycle after release.
- Cycles counted from the handshake cycle (cycle 0):
  - Store: mem_controle_escrita in cycle 1; resp_valido in cycle 2.
  - Load: mem_pulso_leitura in cycle 1; capture at end of cycle 2; resp_valido with resp_dado in cycle 3.
  - Next handshake is possible in cycle 3 after a store and cycle 4 after a load.
- Reset mid-operation:
  - Pending request is abandoned and no response is issued.
  - If reset is sampled at the end of ESCREVE, the memory still writes at that edge.
- resp_dado keeps its last load value except when cleared by reset, a store response or an error response.

## Configuration
- Macro CATCORE_LSU_LIMITE_EN.
- **Defined:**
  - A request with req_endereco >= PROFUNDIDADE issues no memory strobe.
  - It goes OCIOSO→RESPONDE and responds in cycle 1 with resp_erro=1, resp_dado=0.
- **Undefined:**
  - No compare is performed and all addresses are forwarded unchanged.
  - resp_erro is tied to 0.

## Structure
- Shared package catcore_memoria_pkg holds:
  - the state enum;
  - default PROFUNDIDADE (50);
  - default data/address widths.
- No sub-module; the bounds compare is inline in the FSM.

## Test plan
- Reset held 3 cycles, then released: all outputs 0 during reset; req_pronto=1 in the first cycle after release.
- Store addr 5, data 0xDEADBEEF: mem_controle_escrita=1 only in cycle 1 with mem_endereco=5; resp_valido in cycle 2, resp_dado=0.
- Load addr 5 after the store above: mem_pulso_leitura only in cycle 1; resp_valido in cycle 3, resp_dado=0xDEADBEEF.
- req_valido held high for back-to-back load, store, load: accepted only in OCIOSO; handshakes at cycles 0, 4, 7.
- With CATCORE_LSU_LIMITE_EN, load addr 50: no strobe, resp_valido+resp_erro=1 in cycle 1. Without the macro: normal 3-cycle load, resp_erro=0.
- reset asserted during LE_CAPTURA: no resp_valido; req_pronto=1 one cycle after release; next load returns correct data.
